// File: rtl/bgd_scroll_renderer_pkg.sv
// Shared constants and types for the scrolling background renderer.
package bgd_pkg;

  // Default visible raster size.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // One 12-bit colour, 4 bits per channel.
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb4_t;

endpackage

// File: rtl/bgd_scroll_renderer_if.sv
// ROM read bus between the renderer (master) and the external texel ROM (slave).
interface bgd_scroll_renderer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/bgd_scroll_renderer_palette.sv
// Combinational 16-entry palette: index -> 4-bit red/green/blue.
module bgd_palette
  import bgd_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output rgb4_t            rgb
);

  logic [3:0] sel;

  // Table lookup; only the low four index bits select a colour.
  always_comb begin
    sel = 4'(idx);
    rgb = '0;
    case (sel)
      4'd0:  rgb = 12'h000;
      4'd1:  rgb = 12'h00A;
      4'd2:  rgb = 12'h0A0;
      4'd3:  rgb = 12'h0AA;
      4'd4:  rgb = 12'hA00;
      4'd5:  rgb = 12'hA0A;
      4'd6:  rgb = 12'hA50;
      4'd7:  rgb = 12'hAAA;
      4'd8:  rgb = 12'h555;
      4'd9:  rgb = 12'h55F;
      4'd10: rgb = 12'h5F5;
      4'd11: rgb = 12'h5FF;
      4'd12: rgb = 12'hF55;
      4'd13: rgb = 12'hF5F;
      4'd14: rgb = 12'hFF5;
      4'd15: rgb = 12'hFFF;
      default: rgb = 12'h000;
    endcase
  end

endmodule

// File: rtl/bgd_scroll_renderer.sv
// Scaled, vertically scrolling background: maps screen pixels onto a SRC_W x SRC_H
// texel image held in an external ROM, three-stage pipeline to palette RGB.
module bgd_scroll_renderer #(
  parameter int unsigned SRC_W    = 240,
  parameter int unsigned SRC_H    = 180,
  parameter int unsigned H_ACTIVE = bgd_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = bgd_pkg::V_ACTIVE,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic                   scroll_en,
  input  logic                   scroll_dir,
  input  logic [3:0]             scroll_step,
  bgd_scroll_renderer_if.master  rom,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic [IDX_W-1:0]       bg_idx,
  output logic [ADDR_W-1:0]      scroll_off
);

  // Product widths large enough that the scale multiply never overflows.
  localparam int unsigned XW = 10 + $clog2(SRC_W) + 1;
  localparam int unsigned YW = 10 + $clog2(SRC_H) + 1;
  localparam int unsigned OW = ADDR_W + 1;

  logic [XW-1:0]     x_prod, x_div;
  logic [YW-1:0]     y_prod, y_div;
  logic [OW-1:0]     y_sum, off_up, off_dn;
  logic [ADDR_W-1:0] src_x, src_y, rom_addr_d;
  logic [ADDR_W-1:0] scroll_off_q, scroll_off_d;

  logic [ADDR_W-1:0] rom_addr_q;
  logic              blank1_q, blank2_q;
  logic [IDX_W-1:0]  idx_q, bg_idx_q;
  bgd_pkg::rgb4_t    pal_rgb, rgb_q;

  // Screen -> texel mapping; the wrap is one conditional subtract since both terms < SRC_H.
  always_comb begin
    x_prod = XW'(DrawX) * XW'(SRC_W);
    x_div  = x_prod / XW'(H_ACTIVE);
    y_prod = YW'(DrawY) * YW'(SRC_H);
    y_div  = y_prod / YW'(V_ACTIVE);
    src_x  = ADDR_W'(x_div);
    y_sum  = OW'(y_div) + {1'b0, scroll_off_q};
    if (y_sum >= OW'(SRC_H)) begin
      y_sum = y_sum - OW'(SRC_H);
    end
    src_y      = ADDR_W'(y_sum);
    rom_addr_d = src_y * ADDR_W'(SRC_W) + src_x;
  end

  // Next scroll offset, wrapped into 0..SRC_H-1; the extra bit catches borrow on decrement.
  always_comb begin
    off_up = {1'b0, scroll_off_q} + OW'(scroll_step);
    if (off_up >= OW'(SRC_H)) begin
      off_up = off_up - OW'(SRC_H);
    end
    off_dn = {1'b0, scroll_off_q} - OW'(scroll_step);
    if (off_dn[ADDR_W]) begin
      off_dn = off_dn + OW'(SRC_H);
    end
    scroll_off_d = scroll_off_q;
    if (frame_start && scroll_en) begin
      scroll_off_d = ADDR_W'(scroll_dir ? off_dn : off_up);
    end
  end

  // Offset register; reset wins over a coincident frame_start.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      scroll_off_q <= '0;
    end else begin
      scroll_off_q <= scroll_off_d;
    end
  end

  bgd_palette #(
    .IDX_W (IDX_W)
  ) u_palette (
    .idx (idx_q),
    .rgb (pal_rgb)
  );

  // Three-stage pixel pipeline: address, ROM index, palette colour.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr_q <= '0;
      blank1_q   <= 1'b0;
      idx_q      <= '0;
      blank2_q   <= 1'b0;
      rgb_q      <= '0;
      bg_idx_q   <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      blank1_q   <= blank;
      idx_q      <= rom.rom_q;
      blank2_q   <= blank1_q;
      if (blank2_q) begin
        rgb_q    <= pal_rgb;
        bg_idx_q <= idx_q;
      end else begin
        rgb_q    <= '0;
        bg_idx_q <= '0;
      end
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign red          = rgb_q.red;
  assign green        = rgb_q.green;
  assign blue         = rgb_q.blue;
  assign bg_idx       = bg_idx_q;
  assign scroll_off   = scroll_off_q;

endmodule

// File: tb/tb_bgd_scroll_renderer.sv
// Self-checking bench for bgd_scroll_renderer at default parameters.
module tb_bgd_scroll_renderer;

  localparam int SRC_W = 240;
  localparam int SRC_H = 180;
  localparam int HA    = 640;
  localparam int VA    = 480;

  logic        vga_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        scroll_en = 1'b0;
  logic        scroll_dir = 1'b0;
  logic [3:0]  scroll_step = '0;
  logic [3:0]  red, green, blue, bg_idx;
  logic [15:0] scroll_off;
  bit          rom_force5 = 1'b0;

  bgd_scroll_renderer_if #(.ADDR_W(16), .IDX_W(4)) rom_if ();

  bgd_scroll_renderer dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .scroll_dir  (scroll_dir),
    .scroll_step (scroll_step),
    .rom         (rom_if),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .bg_idx      (bg_idx),
    .scroll_off  (scroll_off)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference palette (EGA-like colours).
  logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50,
                            12'hAAA, 12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F,
                            12'hFF5, 12'hFFF};

  function automatic logic [3:0] rom_fn(input logic [15:0] a);
    return a[3:0] ^ a[11:8] ^ a[15:12] ^ 4'(a[7:4] + 4'd3);
  endfunction

  // ROM model: data follows the registered address within the same cycle.
  always_comb rom_if.rom_q = rom_force5 ? 4'd5 : rom_fn(rom_if.rom_addr);

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_start = 1'b0;
    blank = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic pulse(input int step, input bit dir, input bit en);
    scroll_step = 4'(step);
    scroll_dir  = dir;
    scroll_en   = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Reset, then climb to the target offset with upward pulses of at most 15.
  task automatic go_off(input int target);
    int cur;
    int s;
    do_reset();
    check("reset_off", 32'(scroll_off), 0);
    cur = 0;
    while (cur < target) begin
      s = (target - cur > 15) ? 15 : target - cur;
      pulse(s, 1'b0, 1'b1);
      cur += s;
    end
    check("go_off", 32'(scroll_off), 32'(target));
  endtask

  function automatic int model_addr(input int x, input int y, input int off);
    int sy;
    sy = (y * SRC_H / VA + off) % SRC_H;
    return (sy * SRC_W + x * SRC_W / HA) % 65536;
  endfunction

  function automatic logic [15:0] model_pix(input bit blk, input int addr);
    logic [3:0] idx;
    idx = rom_fn(16'(addr));
    return blk ? {pal[idx], idx} : 16'h0;
  endfunction

  typedef struct {
    int off0;
    int step;
    bit dir;
    bit en;
    int exp;
  } scr_vec_t;

  typedef struct {
    int x;
    int y;
    int off;
    int exp;
  } map_vec_t;

  scr_vec_t scr_tab [6];
  map_vec_t map_tab [6];

  logic [15:0] pix_q [$];
  logic [15:0] addr_q [$];
  int          model_off;
  int          a;
  logic [15:0] e_pix;
  logic [15:0] e_addr;

  initial begin
    scr_tab[0] = '{178, 3, 1'b0, 1'b1, 1};
    scr_tab[1] = '{1, 3, 1'b1, 1'b1, 178};
    scr_tab[2] = '{178, 3, 1'b1, 1'b0, 178};
    scr_tab[3] = '{0, 15, 1'b1, 1'b1, 165};
    scr_tab[4] = '{170, 15, 1'b0, 1'b1, 5};
    scr_tab[5] = '{5, 0, 1'b0, 1'b1, 5};

    map_tab[0] = '{639, 479, 0, 43199};
    map_tab[1] = '{0, 300, 100, 7680};
    map_tab[2] = '{320, 240, 0, 21720};
    map_tab[3] = '{3, 3, 0, 241};
    map_tab[4] = '{639, 0, 179, 43199};
    map_tab[5] = '{100, 479, 1, 37};

    // Scroll arithmetic table.
    foreach (scr_tab[i]) begin
      go_off(scr_tab[i].off0);
      pulse(scr_tab[i].step, scr_tab[i].dir, scr_tab[i].en);
      check($sformatf("scroll[%0d]", i), 32'(scroll_off), 32'(scr_tab[i].exp));
    end

    // Down-wrap followed by a disabled pulse that must hold the offset.
    go_off(1);
    pulse(3, 1'b1, 1'b1);
    check("down_wrap", 32'(scroll_off), 178);
    pulse(3, 1'b1, 1'b0);
    check("hold_en0", 32'(scroll_off), 178);

    // Address mapping table: rom_addr one cycle after the coordinates.
    foreach (map_tab[i]) begin
      go_off(map_tab[i].off);
      DrawX = 10'(map_tab[i].x);
      DrawY = 10'(map_tab[i].y);
      blank = 1'b1;
      tick();
      check($sformatf("map[%0d]", i), 32'(rom_if.rom_addr), 32'(map_tab[i].exp));
      blank = 1'b0;
    end

    // Latency and blanking: one visible pixel, then blank.
    rom_force5 = 1'b1;
    do_reset();
    repeat (4) tick();
    blank = 1'b1;
    tick();
    blank = 1'b0;
    tick();
    check("lat_t2", {20'h0, red, green, blue}, 0);
    tick();
    check("lat_t3_rgb", {20'h0, red, green, blue}, 32'(pal[5]));
    check("lat_t3_idx", 32'(bg_idx), 5);
    tick();
    check("lat_t4_rgb", {20'h0, red, green, blue}, 0);
    check("lat_t4_idx", 32'(bg_idx), 0);

    // Reset mid-stream with a coincident enabled frame_start.
    go_off(50);
    blank = 1'b1;
    repeat (4) tick();
    check("pre_rst_rgb", {20'h0, red, green, blue}, 32'(pal[5]));
    Reset = 1'b1;
    scroll_step = 4'd7;
    scroll_dir = 1'b0;
    scroll_en = 1'b1;
    frame_start = 1'b1;
    tick();
    Reset = 1'b0;
    frame_start = 1'b0;
    check("rst_off", 32'(scroll_off), 0);
    check("rst_rgb", {20'h0, red, green, blue}, 0);
    check("rst_idx", 32'(bg_idx), 0);
    check("rst_addr", 32'(rom_if.rom_addr), 0);
    tick();
    tick();
    check("refill_t2", {20'h0, red, green, blue}, 0);
    tick();
    check("refill_t3", {20'h0, red, green, blue}, 32'(pal[5]));
    rom_force5 = 1'b0;

    // Randomized stream against the arithmetic model.
    do_reset();
    model_off = 0;
    pix_q = {16'h0, 16'h0, 16'h0};
    addr_q = {16'h0};
    for (int n = 0; n < 3000; n++) begin
      e_pix = pix_q.pop_front();
      e_addr = addr_q.pop_front();
      check("rnd_pix", {16'h0, red, green, blue, bg_idx}, {16'h0, e_pix});
      check("rnd_addr", 32'(rom_if.rom_addr), 32'(e_addr));
      check("rnd_off", 32'(scroll_off), 32'(model_off));
      DrawX = 10'($urandom_range(639, 0));
      DrawY = 10'($urandom_range(479, 0));
      blank = ($urandom_range(3, 0) != 0);
      frame_start = ($urandom_range(7, 0) == 0);
      scroll_en = 1'($urandom_range(1, 0));
      scroll_dir = 1'($urandom_range(1, 0));
      scroll_step = 4'($urandom_range(15, 0));
      a = model_addr(int'(DrawX), int'(DrawY), model_off);
      addr_q.push_back(16'(a));
      pix_q.push_back(model_pix(blank, a));
      if (frame_start && scroll_en) begin
        if (scroll_dir) model_off = (model_off - int'(scroll_step) + SRC_H) % SRC_H;
        else model_off = (model_off + int'(scroll_step)) % SRC_H;
      end
      tick();
    end
    frame_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bgd_scroll_renderer.md
BGD_SCROLL_RENDERER -- requirements
Module: bgd_scroll_renderer

Interface
REQ-001 SHALL have parameter SRC_W, default 240, meaning source image width in texels.
REQ-002 SHALL have parameter SRC_H, default 180, meaning source image height in texels.
REQ-003 SHALL have parameter H_ACTIVE, default 640, meaning visible screen width in pixels.
REQ-004 SHALL have parameter V_ACTIVE, default 480, meaning visible screen height in pixels.
REQ-005 SHALL have parameter IDX_W, default 4, meaning palette index width in bits.
REQ-006 SHALL have parameter ADDR_W, default 16, meaning ROM address width, with SRC_W*SRC_H <= 2**ADDR_W.
REQ-007 vga_clk  in  1  pixel clock; the only clock.
REQ-008 Reset  in  1  reset, synchronous to vga_clk, active-high.
REQ-009 DrawX  in  10  current pixel column.
REQ-010 DrawY  in  10  current pixel row.
REQ-011 blank  in  1  high while the pixel is visible.
REQ-012 frame_start  in  1  one-cycle pulse, once per frame, during vertical blanking.
REQ-013 scroll_en  in  1  enables the scroll update at frame_start.
REQ-014 scroll_dir  in  1  0 = offset increments (image moves up), 1 = offset decrements.
REQ-015 scroll_step  in  4  texel rows added or subtracted per frame.
REQ-016 rom_addr  out  ADDR_W  registered ROM read address.
REQ-017 rom_q  in  IDX_W  ROM data, valid exactly one vga_clk after rom_addr changes.
REQ-018 red, green, blue  out  4 each  registered pixel colour.
REQ-019 bg_idx  out  IDX_W  palette index aligned with RGB, for downstream compositing.
REQ-020 scroll_off  out  ADDR_W  current vertical offset, range 0..SRC_H-1.

Function
REQ-021 src_x SHALL equal (DrawX*SRC_W)/H_ACTIVE, using integer floor and an intermediate width of at least 10+clog2(SRC_W)+1 bits.
REQ-022 src_y SHALL equal ((DrawY*SRC_H)/V_ACTIVE + scroll_off) mod SRC_H; the mod is a single conditional subtract because both terms are < SRC_H.
REQ-023 Stage 1 SHALL register rom_addr = src_y*SRC_W + src_x, together with the delayed blank.
REQ-024 Stage 2 SHALL register rom_q into an index register and delay blank again.
REQ-025 Stage 3 SHALL register the palette RGB and bg_idx when the delayed blank = 1, and SHALL register 0 for all of them otherwise.
REQ-026 Latency from DrawX/DrawY/blank to red/green/blue/bg_idx SHALL be exactly 3 vga_clk cycles, fully pipelined at 1 pixel per cycle.
REQ-027 scroll_off SHALL change only on a cycle with frame_start=1 and scroll_en=1, and SHALL hold otherwise.
REQ-028 When scroll_dir=0, the next value SHALL be off+step, minus SRC_H if the sum is >= SRC_H.
REQ-029 When scroll_dir=1, the next value SHALL be off-step, plus SRC_H if the difference is negative.
REQ-030 The offset arithmetic SHALL use width ADDR_W+1 to avoid overflow; scroll_step values > SRC_H are unsupported.
REQ-031 When frame_start coincides with visible pixels (misuse), pixels already in the pipeline SHALL keep their issued addresses; the new offset SHALL apply from the next stage-1 computation.

Reset
REQ-032 While Reset=1, the block SHALL clear rom_addr, the index register, all blank delays, red/green/blue, bg_idx and scroll_off to 0 on each vga_clk edge.
REQ-033 Reset SHALL take priority over frame_start.
REQ-034 The first valid colour after Reset deasserts SHALL appear 3 cycles after the first visible input pixel.

Structure
REQ-035 A shared package bgd_pkg SHALL hold the H_ACTIVE/V_ACTIVE constants and the rgb4_t struct {red, green, blue}.
REQ-036 The palette SHALL be one combinational sub-module, bgd_palette (index -> red, green, blue); the ROM SHALL stay external.

Verification
REQ-037 Corner mapping: SRC 240x180, off=0, DrawX=639, DrawY=479 -> rom_addr=43199 one cycle later.
REQ-038 Up-wrap: off=178, step=3, dir=0, en=1, frame_start pulse -> off=1.
REQ-039 Down-wrap: off=1, step=3, dir=1 -> off=178; repeat with en=0 -> off stays 178.
REQ-040 Blanking and latency: ROM model returns index 5; blank=1 then 0 on consecutive cycles -> RGB = palette[5] at cycle t+3, then 0 at t+4.
REQ-041 Scrolled mapping: off=100, DrawX=0, DrawY=300 (src_y row 112+100-180=32) -> rom_addr=7680.
REQ-042 Reset mid-stream: Reset held 1 cycle with off=50 -> off=0, RGB=0 next cycle, and the pipeline refills after 3 cycles.
